// File: rtl/vertex_fetch.sv
// vertex_fetch: loads the MVP matrix into the vertex shader, then streams N
// vertices from the vertex buffer RAM (one cycle read latency) through a
// 2-entry output/skid buffer that honours shader backpressure. It tags the
// final vertex, waits for the shader's finished pulse and pulses done.
//
// Optional feature: define VERTEX_FETCH_BASE_ADDR_EN to add i_base_addr.
// Vertex k is then read from (base + k) mod 2^ADDRWIDTH instead of from k.
module vertex_fetch #(
  parameter int unsigned DATAWIDTH = 24,
  parameter int unsigned ADDRWIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_start,
  input  logic        [ADDRWIDTH-1:0] i_num_vertices,
  input  logic signed [DATAWIDTH-1:0] i_mvp_mat [4][4],
`ifdef VERTEX_FETCH_BASE_ADDR_EN
  input  logic        [ADDRWIDTH-1:0] i_base_addr,
`endif
  output logic                        o_busy,
  output logic                        o_done,
  output logic        [ADDRWIDTH-1:0] o_vbuf_addr,
  output logic                        o_vbuf_re,
  input  logic signed [DATAWIDTH-1:0] i_vbuf_data [3],
  output logic signed [DATAWIDTH-1:0] o_mvp_mat [4][4],
  output logic                        o_mvp_dv,
  input  logic                        i_shader_ready,
  input  logic                        i_shader_finished,
  output logic signed [DATAWIDTH-1:0] o_vertex [3],
  output logic                        o_vertex_dv,
  output logic                        o_vertex_last
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadMvp,
    StStream,
    StWaitFinish,
    StDone
  } state_e;

  localparam logic [ADDRWIDTH-1:0] AddrOne = ADDRWIDTH'(1);

  state_e state_q, state_d;

  // Draw parameters captured on an accepted start.
  logic        [ADDRWIDTH-1:0] num_q, num_d;
  logic signed [DATAWIDTH-1:0] mat_q [4][4];
  logic signed [DATAWIDTH-1:0] mat_d [4][4];
`ifdef VERTEX_FETCH_BASE_ADDR_EN
  logic        [ADDRWIDTH-1:0] base_q, base_d;
`endif

  // Read issue and transfer progress.
  logic [ADDRWIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDRWIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
  logic                 rd_pend_q, rd_pend_d;

  // Two-entry buffer: head drives o_vertex, skid catches data landing while stalled.
  logic signed [DATAWIDTH-1:0] head_q [3];
  logic signed [DATAWIDTH-1:0] head_d [3];
  logic signed [DATAWIDTH-1:0] skid_q [3];
  logic signed [DATAWIDTH-1:0] skid_d [3];
  logic                        head_vld_q, head_vld_d;
  logic                        skid_vld_q, skid_vld_d;

  logic       start_acc;
  logic       xfer;
  logic       last_xfer;
  logic       reads_left;
  logic [1:0] occ;
  logic [1:0] occ_after;
  logic       rd_issue;

  // Handshake decode: transfer, last tag and read-issue decision.
  always_comb begin
    start_acc  = (state_q == StIdle) && i_start;
    xfer       = head_vld_q && i_shader_ready && (state_q == StStream);
    last_xfer  = xfer && (xfer_cnt_q == (num_q - AddrOne));
    reads_left = (rd_cnt_q != num_q);
    occ        = {1'b0, head_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_pend_q};
    // A transfer only happens with the head valid, so this never underflows.
    occ_after  = occ - {1'b0, xfer};
    rd_issue   = ((state_q == StLoadMvp) || (state_q == StStream)) && reads_left &&
                 (occ_after <= 2'd1);
  end

  // Next-state logic for the draw sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = (i_num_vertices == '0) ? StDone : StLoadMvp;
        end
      end
      StLoadMvp:    state_d = StStream;
      StStream:     if (last_xfer) state_d = StWaitFinish;
      StWaitFinish: if (i_shader_finished) state_d = StDone;
      StDone:       state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  // Next-state for latched draw parameters and progress counters.
  always_comb begin
    num_d      = num_q;
    mat_d      = mat_q;
    rd_cnt_d   = rd_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    rd_pend_d  = rd_issue;
`ifdef VERTEX_FETCH_BASE_ADDR_EN
    base_d     = base_q;
`endif
    if (start_acc) begin
      num_d      = i_num_vertices;
      mat_d      = i_mvp_mat;
      rd_cnt_d   = '0;
      xfer_cnt_d = '0;
`ifdef VERTEX_FETCH_BASE_ADDR_EN
      base_d     = i_base_addr;
`endif
    end else begin
      if (rd_issue) rd_cnt_d = rd_cnt_q + AddrOne;
      if (xfer)     xfer_cnt_d = xfer_cnt_q + AddrOne;
    end
  end

  // Buffer update: pop on transfer, push when the outstanding read returns.
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    if (xfer) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        skid_vld_d = rd_pend_q;
        if (rd_pend_q) skid_d = i_vbuf_data;
      end else begin
        head_vld_d = rd_pend_q;
        if (rd_pend_q) head_d = i_vbuf_data;
      end
    end else if (rd_pend_q) begin
      // Issue rule keeps held + outstanding <= 2, so the skid is free here.
      if (!head_vld_q) begin
        head_vld_d = 1'b1;
        head_d     = i_vbuf_data;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = i_vbuf_data;
      end
    end
  end

  // State, parameter and buffer registers; reset also drops any in-flight read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      num_q      <= '0;
      rd_cnt_q   <= '0;
      xfer_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
`ifdef VERTEX_FETCH_BASE_ADDR_EN
      base_q     <= '0;
`endif
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          mat_q[r][c] <= '0;
        end
      end
      for (int i = 0; i < 3; i++) begin
        head_q[i] <= '0;
        skid_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      mat_q      <= mat_d;
      rd_cnt_q   <= rd_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      rd_pend_q  <= rd_pend_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
`ifdef VERTEX_FETCH_BASE_ADDR_EN
      base_q     <= base_d;
`endif
    end
  end

  // Outputs are decoded from registered state so reset clears them immediately.
  always_comb begin
    o_busy        = (state_q != StIdle);
    o_done        = (state_q == StDone);
    o_mvp_dv      = (state_q == StLoadMvp);
    o_vbuf_re     = rd_issue;
`ifdef VERTEX_FETCH_BASE_ADDR_EN
    o_vbuf_addr   = base_q + rd_cnt_q;
`else
    o_vbuf_addr   = rd_cnt_q;
`endif
    o_vertex_dv   = xfer;
    o_vertex_last = last_xfer;
    o_vertex      = head_q;
    o_mvp_mat     = mat_q;
  end

endmodule

// File: tb/tb_vertex_fetch.sv
// Self-checking bench for vertex_fetch: a behavioural vertex RAM, a scoreboard
// of expected read addresses and vertices pushed when a draw starts and popped
// as the DUT reads/transfers, plus directed cycle-accurate timing checks.
module tb_vertex_fetch;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 10;

  typedef struct packed {
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] z;
    logic                 last;
  } vtx_t;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 i_start = 1'b0;
  logic        [AW-1:0] i_num_vertices = '0;
  logic signed [DW-1:0] i_mvp_mat [4][4];
`ifdef VERTEX_FETCH_BASE_ADDR_EN
  logic        [AW-1:0] i_base_addr = '0;
`endif
  logic                 o_busy;
  logic                 o_done;
  logic        [AW-1:0] o_vbuf_addr;
  logic                 o_vbuf_re;
  logic signed [DW-1:0] i_vbuf_data [3];
  logic signed [DW-1:0] o_mvp_mat [4][4];
  logic                 o_mvp_dv;
  logic                 i_shader_ready = 1'b0;
  logic                 i_shader_finished = 1'b0;
  logic signed [DW-1:0] o_vertex [3];
  logic                 o_vertex_dv;
  logic                 o_vertex_last;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_re, n_dv, n_mvp, n_done, n_last;
  int xfer_cyc [$];
  int last_cyc [$];
  logic [AW-1:0] exp_addr_q [$];
  vtx_t          exp_vtx_q [$];

  vertex_fetch #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_start          (i_start),
    .i_num_vertices   (i_num_vertices),
    .i_mvp_mat        (i_mvp_mat),
`ifdef VERTEX_FETCH_BASE_ADDR_EN
    .i_base_addr      (i_base_addr),
`endif
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_vbuf_addr      (o_vbuf_addr),
    .o_vbuf_re        (o_vbuf_re),
    .i_vbuf_data      (i_vbuf_data),
    .o_mvp_mat        (o_mvp_mat),
    .o_mvp_dv         (o_mvp_dv),
    .i_shader_ready   (i_shader_ready),
    .i_shader_finished(i_shader_finished),
    .o_vertex         (o_vertex),
    .o_vertex_dv      (o_vertex_dv),
    .o_vertex_last    (o_vertex_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Vertex RAM contents are a fixed function of address.
  function automatic logic signed [DW-1:0] vdat(input logic [AW-1:0] a, input int c);
    int v;
    int ai;
    ai = int'(a);
    if (c == 0)      v = ai * 5 + 3;
    else if (c == 1) v = -(ai * 7) - 1;
    else             v = (ai * 131) ^ 'h5a5a5;
    return DW'(v);
  endfunction

  function automatic logic signed [DW-1:0] mat_val(input int seed, input int r, input int c);
    int v;
    v = seed * 1000 - r * 37 + c * 11 - 50;
    return DW'(v);
  endfunction

  // One-cycle-latency RAM model.
  always @(posedge clk) begin
    if (o_vbuf_re) begin
      for (int c = 0; c < 3; c++) i_vbuf_data[c] <= vdat(o_vbuf_addr, c);
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops and event counting, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_vbuf_re) begin
        n_re++;
        if (exp_addr_q.size() == 0) begin
          check("re_extra", 1, 0);
        end else begin
          check("addr", o_vbuf_addr, exp_addr_q.pop_front());
        end
        // Held entries plus the new outstanding read never exceed two.
        check("occ_le2", ((n_re - n_dv - (o_vertex_dv ? 1 : 0)) <= 2) ? 1 : 0, 1);
      end
      if (o_vertex_dv) begin
        n_dv++;
        xfer_cyc.push_back(cyc - start_cyc);
        if (exp_vtx_q.size() == 0) begin
          check("dv_extra", 1, 0);
        end else begin
          vtx_t e;
          e = exp_vtx_q.pop_front();
          check("vtx_x", o_vertex[0], e.x);
          check("vtx_y", o_vertex[1], e.y);
          check("vtx_z", o_vertex[2], e.z);
          check("vtx_last", o_vertex_last, e.last);
        end
      end else if (o_vertex_last) begin
        check("last_without_dv", 1, 0);
      end
      if (o_vertex_last) begin
        n_last++;
        last_cyc.push_back(cyc - start_cyc);
      end
      if (o_mvp_dv) n_mvp++;
      if (o_done)   n_done++;
    end
  end

  task automatic set_mat(input int seed);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) i_mvp_mat[r][c] = mat_val(seed, r, c);
    end
  endtask

  task automatic check_mat(input string tag, input int seed);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) check(tag, o_mvp_mat[r][c], mat_val(seed, r, c));
    end
  endtask

  // Drives start in cycle 0 and pushes the expected read/transfer stream.
  task automatic start_draw(input int n, input int seed, input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    n_re = 0; n_dv = 0; n_mvp = 0; n_done = 0; n_last = 0;
    xfer_cyc.delete();
    last_cyc.delete();
    i_start = 1'b1;
    i_num_vertices = AW'(n);
    set_mat(seed);
`ifdef VERTEX_FETCH_BASE_ADDR_EN
    i_base_addr = base;
`endif
    for (int k = 0; k < n; k++) begin
      logic [AW-1:0] a;
      vtx_t v;
      a = base + AW'(k);
      exp_addr_q.push_back(a);
      v.x = vdat(a, 0);
      v.y = vdat(a, 1);
      v.z = vdat(a, 2);
      v.last = (k == n - 1);
      exp_vtx_q.push_back(v);
    end
  endtask

  // Returns 1 time unit into cycle k of the current draw.
  task automatic to_cycle(input int k);
    int g;
    g = 0;
    while ((cyc - start_cyc) < k && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
  endtask

  task automatic wait_xfers(input int n);
    int g;
    g = 0;
    while (n_dv < n && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("xfer_count", n_dv, n);
  endtask

  // Pulses finished in WAIT_FINISH; done must follow one cycle later.
  task automatic finish_draw();
    @(posedge clk);
    #1;
    i_shader_finished = 1'b1;
    @(negedge clk);
    check("done_early", o_done, 0);
    @(posedge clk);
    #1;
    i_shader_finished = 1'b0;
    @(negedge clk);
    check("done", o_done, 1);
    @(negedge clk);
    check("idle_after_done", o_busy, 0);
    check("sb_addr_empty", exp_addr_q.size(), 0);
    check("sb_vtx_empty", exp_vtx_q.size(), 0);
  endtask

  initial begin
    logic [6:0] pat;
    int         ones;
    set_mat(0);
    for (int c = 0; c < 3; c++) i_vbuf_data[c] = '0;
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_re", o_vbuf_re, 0);
    check("rst_dv", o_vertex_dv, 0);
    check("rst_mvp_dv", o_mvp_dv, 0);
    check("rst_mat", o_mvp_mat[1][2], 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Full throughput, N=3.
    i_shader_ready = 1'b1;
    start_draw(3, 1, '0);
    @(negedge clk);
    check("c0_busy", o_busy, 0);
    check("c0_mvp_dv", o_mvp_dv, 0);
    to_cycle(1);
    i_start = 1'b0;
    @(negedge clk);
    check("c1_mvp_dv", o_mvp_dv, 1);
    check("c1_re", o_vbuf_re, 1);
    check("c1_addr", o_vbuf_addr, 0);
    check("c1_busy", o_busy, 1);
    check_mat("c1_mat", 1);
    to_cycle(2);
    @(negedge clk);
    check("c2_re", o_vbuf_re, 1);
    check("c2_addr", o_vbuf_addr, 1);
    check("c2_mvp_dv", o_mvp_dv, 0);
    to_cycle(10);
    i_shader_finished = 1'b1;
    @(negedge clk);
    check("c10_done", o_done, 0);
    to_cycle(11);
    i_shader_finished = 1'b0;
    @(negedge clk);
    check("c11_done", o_done, 1);
    to_cycle(12);
    @(negedge clk);
    check("c12_busy", o_busy, 0);
    check("t1_n_xfer", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) check("t1_xfer_cycle", xfer_cyc[i], 3 + i);
    end
    check("t1_n_last", last_cyc.size(), 1);
    if (last_cyc.size() == 1) check("t1_last_cycle", last_cyc[0], 5);
    check("t1_n_mvp", n_mvp, 1);

    // Backpressure, N=4: ready pattern 1,0,0,1,0,1,1 from cycle 3 (bit 0 first).
    pat = 7'b1101001;
    i_shader_ready = 1'b1;
    start_draw(4, 2, '0);
    to_cycle(1);
    i_start = 1'b0;
    ones = 0;
    for (int k = 0; k < 7; k++) begin
      to_cycle(3 + k);
      i_shader_ready = pat[k];
      @(negedge clk);
      if (!pat[k]) begin
        check("stall_dv", o_vertex_dv, 0);
        check("stall_x", o_vertex[0], vdat(AW'(ones), 0));
        check("stall_y", o_vertex[1], vdat(AW'(ones), 1));
        check("stall_z", o_vertex[2], vdat(AW'(ones), 2));
      end else begin
        ones++;
      end
    end
    i_shader_ready = 1'b1;
    wait_xfers(4);
    check("t2_n_last", n_last, 1);
    finish_draw();
    check("t2_n_re", n_re, 4);

    // Empty draw.
    start_draw(0, 3, '0);
    @(negedge clk);
    check("t3_c0_done", o_done, 0);
    to_cycle(1);
    i_start = 1'b0;
    @(negedge clk);
    check("t3_c1_done", o_done, 1);
    to_cycle(5);
    @(negedge clk);
    check("t3_busy", o_busy, 0);
    check("t3_n_mvp", n_mvp, 0);
    check("t3_n_re", n_re, 0);
    check("t3_n_dv", n_dv, 0);
    check("t3_n_done", n_done, 1);

    // Reset after the 2nd transfer of N=5.
    i_shader_ready = 1'b1;
    start_draw(5, 4, '0);
    to_cycle(1);
    i_start = 1'b0;
    wait_xfers(2);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("ar_busy", o_busy, 0);
    check("ar_done", o_done, 0);
    check("ar_re", o_vbuf_re, 0);
    check("ar_addr", o_vbuf_addr, 0);
    check("ar_dv", o_vertex_dv, 0);
    check("ar_last", o_vertex_last, 0);
    check("ar_mvp_dv", o_mvp_dv, 0);
    check("ar_vx", o_vertex[0], 0);
    check("ar_vz", o_vertex[2], 0);
    check("ar_mat", o_mvp_mat[3][3], 0);
    exp_addr_q.delete();
    exp_vtx_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    start_draw(2, 5, '0);
    to_cycle(1);
    i_start = 1'b0;
    wait_xfers(2);
    finish_draw();
    check("t4_n_re", n_re, 2);

    // Start pulses during STREAM and WAIT_FINISH are ignored.
    i_shader_ready = 1'b0;
    start_draw(3, 6, '0);
    to_cycle(1);
    i_start = 1'b0;
    to_cycle(4);
    i_start = 1'b1;
    i_num_vertices = AW'(7);
    set_mat(9);
    to_cycle(5);
    i_start = 1'b0;
    i_shader_ready = 1'b1;
    wait_xfers(3);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_num_vertices = AW'(9);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    @(negedge clk);
    check("t5_busy_wait", o_busy, 1);
    check("t5_done_wait", o_done, 0);
    finish_draw();
    repeat (3) @(negedge clk);
    check("t5_n_re", n_re, 3);
    check("t5_n_dv", n_dv, 3);
    check("t5_n_mvp", n_mvp, 1);
    check_mat("t5_mat", 6);

`ifdef VERTEX_FETCH_BASE_ADDR_EN
    // Base address wrap: 1022, 1023, 0, 1.
    i_shader_ready = 1'b1;
    start_draw(4, 7, AW'(1022));
    to_cycle(1);
    i_start = 1'b0;
    wait_xfers(4);
    finish_draw();
    check("t6_n_re", n_re, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
